i2c_slave_rx: RTL and testbench
===============================

Name: i2c_slave_rx

Overview:
Write-only I2C target receiver. It sits directly downstream of the I2C master driver and consumes that driver's sclk/sda lines. It oversamples both lines in the system clock domain and detects START/STOP. It decodes the 7-bit address and R/W bit, ACKs a matching write address, and then delivers each received data byte on a valid/ready interface, ACKing or NACKing per byte.

Parameters:
ADDRESS, 27, 7-bit target address this block responds to.
SYNC_STAGES, 2, synchronizer flops on sclk and sda (minimum 2).

Ports:
clk  input  1  system clock; must be at least 8x the SCL bit rate.
reset  input  1  asynchronous, active-low reset.
sclk  input  1  I2C clock line from the bus.
sda  input  1  I2C data line from the bus, wired-AND with sda_drive_low.
sda_drive_low  output  1  1 = pull SDA low (ACK); 0 = release.
rx_data  output  8  last received data byte, MSB first on the wire.
rx_valid  output  1  one-cycle pulse: rx_data is new.
rx_ready  input  1  consumer can accept a byte; sampled at 8th data bit.
rx_first  output  1  qualifies rx_valid: byte is first after address.
overflow  output  1  one-cycle pulse: byte NACKed/dropped because rx_ready=0.
busy  output  1  high from START detection until STOP detection.
addr_match  output  1  high from address ACK until STOP or repeated START.

Behaviour:
- Reset (reset=0, async): state IDLE, sda_drive_low=0 immediately, rx_data=0, all pulses/flags 0, synchronizers preset to 1 (idle bus).
- Line sync: sclk and sda pass through SYNC_STAGES flops, then one edge register.
  - scl_rise/scl_fall = edge of synced SCL.
  - START = synced SDA 1->0 while synced SCL=1. STOP = synced SDA 0->1 while synced SCL=1.
  - Detection latency is SYNC_STAGES+1 clk after the pin change.
- Data bits are sampled on scl_rise. SDA output changes only on scl_fall, or on START, STOP or reset.
- 3-bit bit counter; byte shift register is 8 bits, MSB first.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits (7 address bits + R/W). At the 8th scl_rise, compare.
    - If address == ADDRESS and R/W == 0 -> ADDR_ACK.
    - Otherwise -> IGNORE. This covers a mismatch and any read request (NACK, line released).
  - ADDR_ACK: on the next scl_fall assert sda_drive_low and set addr_match. Hold through the ACK scl_rise. On the following scl_fall release and go to DATA with bit counter=0 and rx_first armed.
  - DATA: shift 8 bits. At the 8th scl_rise:
    - If rx_ready=1: load rx_data, pulse rx_valid the next clk (with rx_first if armed, then disarm), go to DATA_ACK with ack=1.
    - If rx_ready=0: rx_data unchanged, pulse overflow, go to DATA_ACK with ack=0.
  - DATA_ACK: on scl_fall drive sda_drive_low=ack. On the next scl_fall release and return to DATA.
  - IGNORE: line released; wait for STOP or START.
- START in any state (including a repeated START mid-byte or mid-ACK): release SDA, clear bit counter and addr_match, busy=1, go to ADDR.
- STOP in any state: release SDA, clear addr_match and busy, go to IDLE. A partial byte is discarded with no rx_valid.
- START/STOP and scl edges are mutually exclusive by definition, since START/STOP require SCL steady high. If START and STOP are flagged in the same clk, STOP wins.
- Master NACK is not applicable because the block is write-only.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE).
  - I2C_ADDR_W=7.
  - I2C_RW_WRITE=0.
  - default address constant 27, shared with the master driver.
- One sub-module, i2c_line_sync: synchronizers, edge register, and outputs scl_rise, scl_fall, sda_s, start_det, stop_det.

Test Plan:
- START, address 27 (0x36 with W), byte 0xA5, STOP, rx_ready=1 -> SDA pulled low in both ACK slots; rx_data=0xA5; rx_valid and rx_first pulse once; busy falls after STOP.
- START, address 0x10 W, byte 0xFF -> sda_drive_low never asserts; no rx_valid; addr_match stays 0.
- START, address 27 with R (0x37) -> NACK; state IGNORE until STOP; no pulses.
- Address 27 W, bytes 0x11 then 0x22, with rx_ready=0 at the second byte's 8th bit -> first byte ACKed (rx_valid, rx_first); second byte NACKed, overflow pulse, rx_data stays 0x11.
- Address 27 W, 4 bits of data, repeated START, address 27 W, byte 0x3C -> partial byte dropped; fresh address ACK; rx_data=0x3C with rx_first=1.
- reset driven low during the DATA_ACK low phase -> sda_drive_low drops within the same clk without a clock edge; after release, state IDLE and the next transaction is received normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: receiver state encoding and address constants
// common to the master driver and the target receiver.
package i2c_pkg;

   localparam int                    I2C_ADDR_W       = 7;
   localparam logic                  I2C_RW_WRITE     = 1'b0;
   localparam logic [I2C_ADDR_W-1:0] I2C_DEFAULT_ADDR = 7'd27;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      DATA,
      DATA_ACK,
      IGNORE
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings sclk/sda into the clk domain and flags SCL edges and START/STOP.
// Synchronizers preset to 1 so a reset never fakes an edge on an idle bus.
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic sclk,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic sda_s,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_s;
   logic                   scl_d;
   logic                   sda_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments make every stage sample the previous
         // stage's old value, so the chain shifts by one flop per clk.
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], sclk};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & sda_d & ~sda_s;
   assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: decodes address + W, ACKs a match, then hands each
// data byte to a valid/ready consumer, NACKing bytes the consumer refuses.
module i2c_slave_rx
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] ADDRESS     = I2C_DEFAULT_ADDR,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sclk,
   input  logic       sda,
   output logic       sda_drive_low,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_first,
   output logic       overflow,
   output logic       busy,
   output logic       addr_match
);

   logic scl_rise, scl_fall, sda_s, start_det, stop_det;

   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
      .clk       (clk),
      .reset     (reset),
      .sclk      (sclk),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .sda_s     (sda_s),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   i2c_state_e state, state_nxt;
   logic [2:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] shreg, shreg_nxt;
   logic [7:0] rx_data_nxt;
   logic [7:0] shift_in;
   logic       rx_valid_nxt, rx_first_nxt, overflow_nxt;
   logic       sda_drive_low_nxt, addr_match_nxt, busy_nxt;
   logic       first_armed, first_armed_nxt;
   logic       ack, ack_nxt;
   // Distinguishes the scl_fall that opens an ACK slot from the one closing it.
   logic       ack_phase, ack_phase_nxt;

   assign shift_in = {shreg[6:0], sda_s};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         bit_cnt       <= '0;
         shreg         <= '0;
         rx_data       <= '0;
         rx_valid      <= 1'b0;
         rx_first      <= 1'b0;
         overflow      <= 1'b0;
         sda_drive_low <= 1'b0;
         addr_match    <= 1'b0;
         busy          <= 1'b0;
         first_armed   <= 1'b0;
         ack           <= 1'b0;
         ack_phase     <= 1'b0;
      end else begin
         state         <= state_nxt;
         bit_cnt       <= bit_cnt_nxt;
         shreg         <= shreg_nxt;
         rx_data       <= rx_data_nxt;
         rx_valid      <= rx_valid_nxt;
         rx_first      <= rx_first_nxt;
         overflow      <= overflow_nxt;
         sda_drive_low <= sda_drive_low_nxt;
         addr_match    <= addr_match_nxt;
         busy          <= busy_nxt;
         first_armed   <= first_armed_nxt;
         ack           <= ack_nxt;
         ack_phase     <= ack_phase_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default before any branch,
      // otherwise an unassigned path would infer a latch.
      state_nxt         = state;
      bit_cnt_nxt       = bit_cnt;
      shreg_nxt         = shreg;
      rx_data_nxt       = rx_data;
      rx_valid_nxt      = 1'b0;
      rx_first_nxt      = 1'b0;
      overflow_nxt      = 1'b0;
      sda_drive_low_nxt = sda_drive_low;
      addr_match_nxt    = addr_match;
      busy_nxt          = busy;
      first_armed_nxt   = first_armed;
      ack_nxt           = ack;
      ack_phase_nxt     = ack_phase;

      if (stop_det) begin
         state_nxt         = IDLE;
         bit_cnt_nxt       = '0;
         sda_drive_low_nxt = 1'b0;
         addr_match_nxt    = 1'b0;
         busy_nxt          = 1'b0;
         first_armed_nxt   = 1'b0;
      end else if (start_det) begin
         state_nxt         = ADDR;
         bit_cnt_nxt       = '0;
         sda_drive_low_nxt = 1'b0;
         addr_match_nxt    = 1'b0;
         busy_nxt          = 1'b1;
         first_armed_nxt   = 1'b0;
      end else begin
         unique case (state)
            IDLE: ;
            ADDR: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_phase_nxt = 1'b0;
                     if (shift_in[7:1] == ADDRESS && shift_in[0] == I2C_RW_WRITE)
                        state_nxt = ADDR_ACK;
                     else
                        state_nxt = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_drive_low_nxt = 1'b1;
                     addr_match_nxt    = 1'b1;
                     ack_phase_nxt     = 1'b1;
                  end else begin
                     sda_drive_low_nxt = 1'b0;
                     bit_cnt_nxt       = '0;
                     first_armed_nxt   = 1'b1;
                     state_nxt         = DATA;
                  end
               end
            end
            DATA: begin
               if (scl_rise) begin
                  shreg_nxt   = shift_in;
                  bit_cnt_nxt = bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     ack_phase_nxt = 1'b0;
                     state_nxt     = DATA_ACK;
                     if (rx_ready) begin
                        rx_data_nxt     = shift_in;
                        rx_valid_nxt    = 1'b1;
                        rx_first_nxt    = first_armed;
                        first_armed_nxt = 1'b0;
                        ack_nxt         = 1'b1;
                     end else begin
                        overflow_nxt = 1'b1;
                        ack_nxt      = 1'b0;
                     end
                  end
               end
            end
            DATA_ACK: begin
               if (scl_fall) begin
                  if (!ack_phase) begin
                     sda_drive_low_nxt = ack;
                     ack_phase_nxt     = 1'b1;
                  end else begin
                     sda_drive_low_nxt = 1'b0;
                     bit_cnt_nxt       = '0;
                     state_nxt         = DATA;
                  end
               end
            end
            IGNORE: sda_drive_low_nxt = 1'b0;
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Self-checking bench for i2c_slave_rx: a bit-level I2C master plus a
// transaction-level model of which slots get ACKed and which bytes come out.
module tb_i2c_slave_rx;

   localparam logic [6:0] ADDRESS = 7'd27;
   localparam int         Q       = 6;   // quarter SCL period in clk cycles

   logic       clk = 1'b0;
   logic       reset;
   logic       sclk;
   logic       sda_m;
   logic       sda;
   logic       sda_drive_low;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       rx_first;
   logic       overflow;
   logic       busy;
   logic       addr_match;

   assign sda = sda_m & ~sda_drive_low;

   i2c_slave_rx #(.ADDRESS(ADDRESS), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .sclk          (sclk),
      .sda           (sda),
      .sda_drive_low (sda_drive_low),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_ready      (rx_ready),
      .rx_first      (rx_first),
      .overflow      (overflow),
      .busy          (busy),
      .addr_match    (addr_match)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   // Output monitor, sampled on the falling clk edge.
   int         n_valid = 0;
   int         n_ovf   = 0;
   logic       last_first;
   always @(negedge clk) begin
      if (rx_valid) begin
         n_valid++;
         last_first = rx_first;
      end
      if (overflow) n_ovf++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic m_start();
      sda_m = 1'b1; wait_clk(Q);
      sclk  = 1'b1; wait_clk(Q);
      sda_m = 1'b0; wait_clk(Q);
      sclk  = 1'b0; wait_clk(Q);
   endtask

   task automatic m_stop();
      sda_m = 1'b0; wait_clk(Q);
      sclk  = 1'b1; wait_clk(2 * Q);
      sda_m = 1'b1; wait_clk(2 * Q);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;    wait_clk(Q);
      sclk  = 1'b1; wait_clk(2 * Q);
      sclk  = 1'b0; wait_clk(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic acked);
      for (int i = 7; i >= 0; i--) write_bit(b[i]);
      sda_m = 1'b1; wait_clk(Q);
      sclk  = 1'b1; wait_clk(Q);
      acked = ~sda;
      wait_clk(Q);
      sclk  = 1'b0; wait_clk(Q);
   endtask

   // Model state: last byte the consumer accepted.
   logic [7:0] exp_rx_data;
   logic [7:0] tx_data [8];
   logic       tx_rdy  [8];

   task automatic xfer(input logic [7:0] abyte, input int nb, input bit do_stop);
      logic a, match, exp_ack, first;
      int   v0, o0;
      m_start();
      check("busy_after_start", busy, 1);
      match = (abyte[7:1] == ADDRESS) && (abyte[0] == 1'b0);
      write_byte(abyte, a);
      check("addr_ack", a, match);
      check("addr_match", addr_match, match);
      first = 1'b1;
      for (int i = 0; i < nb; i++) begin
         rx_ready = tx_rdy[i];
         v0 = n_valid;
         o0 = n_ovf;
         write_byte(tx_data[i], a);
         exp_ack = match && tx_rdy[i];
         check("data_ack", a, exp_ack);
         check("valid_pulses", n_valid - v0, exp_ack);
         check("overflow_pulses", n_ovf - o0, match && !tx_rdy[i]);
         if (exp_ack) begin
            exp_rx_data = tx_data[i];
            check("rx_first", last_first, first);
            first = 1'b0;
         end
         check("rx_data", rx_data, exp_rx_data);
      end
      if (do_stop) begin
         m_stop();
         check("busy_after_stop", busy, 0);
         check("addr_match_after_stop", addr_match, 0);
      end
   endtask

   initial begin
      logic a;
      int   v0, sel, nb;
      logic [7:0] abyte;

      reset = 1'b0; sclk = 1'b1; sda_m = 1'b1; rx_ready = 1'b0;
      exp_rx_data = 8'h00;
      wait_clk(4);
      check("reset_sda_drive_low", sda_drive_low, 0);
      check("reset_rx_data", rx_data, 0);
      check("reset_busy", busy, 0);
      check("reset_addr_match", addr_match, 0);
      check("reset_rx_valid", rx_valid, 0);
      reset = 1'b1;
      wait_clk(4);

      // Matching write, one byte.
      tx_data[0] = 8'hA5; tx_rdy[0] = 1'b1;
      xfer(8'h36, 1, 1'b1);

      // Non-matching address, then read request to our address.
      tx_data[0] = 8'hFF; tx_rdy[0] = 1'b1;
      xfer(8'h20, 1, 1'b1);
      xfer(8'h37, 1, 1'b1);

      // Second byte refused by the consumer.
      tx_data[0] = 8'h11; tx_rdy[0] = 1'b1;
      tx_data[1] = 8'h22; tx_rdy[1] = 1'b0;
      xfer(8'h36, 2, 1'b1);

      // Partial byte cut off by a repeated START.
      rx_ready = 1'b1;
      m_start();
      write_byte(8'h36, a);
      check("rs_addr_ack", a, 1);
      v0 = n_valid;
      for (int i = 0; i < 4; i++) write_bit(1'b1);
      tx_data[0] = 8'h3C; tx_rdy[0] = 1'b1;
      xfer(8'h36, 1, 1'b1);
      check("rs_partial_dropped", n_valid - v0, 1);

      // Asynchronous reset in the middle of a data ACK slot.
      rx_ready = 1'b1;
      m_start();
      write_byte(8'h36, a);
      for (int i = 7; i >= 0; i--) write_bit(i[0]);
      sda_m = 1'b1;
      check("ack_driven_before_reset", sda_drive_low, 1);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check("async_reset_release", sda_drive_low, 0);
      sclk = 1'b1; sda_m = 1'b1;
      exp_rx_data = 8'h00;
      wait_clk(2);
      check("reset_mid_busy", busy, 0);
      check("reset_mid_rx_data", rx_data, 0);
      reset = 1'b1;
      wait_clk(4);
      tx_data[0] = 8'h5A; tx_rdy[0] = 1'b1;
      xfer(8'h36, 1, 1'b1);

      // Randomized transactions.
      for (int t = 0; t < 20; t++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0, 1:    abyte = 8'h36;
            2:       abyte = 8'h37;
            default: abyte = 8'($urandom);
         endcase
         nb = $urandom_range(1, 3);
         for (int i = 0; i < nb; i++) begin
            tx_data[i] = 8'($urandom);
            tx_rdy[i]  = ($urandom_range(0, 3) != 0);
         end
         xfer(abyte, nb, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation did not finish, got %0d checks", n_checks);
      $fatal(1, "timeout");
   end

endmodule
